result_readout: RTL and testbench

- Read side of the result RAM that the multiply/accumulate FSM writes.
- A debounced direction button selects one of the four 2x2 result elements. The block reads that element from RAM, converts it to BCD with a sequential double-dabble, and time-multiplexes the value onto the 4-digit seven-segment display.
- Instantiated in top as `seg`, between the button debouncers, the result RAM and the display pins.

---
 rtl/result_readout.sv | 270 +++++++++++++++++++++++++++
 tb/tb_result_readout.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_readout.sv
`default_nettype none
// ============================================================================
//  Module   : result_readout
//  Purpose  : Read side of the 2x2 result RAM. A debounced direction button
//             picks one result element, the element is read from RAM,
//             converted to BCD by a sequential double-dabble and scanned onto
//             a 4-digit seven-segment display (element number + 3 digits).
//  Ports    : clk, rst (async, active-high)
//             up/left/right/down_clean - debounced button levels
//             results_valid            - result RAM contents are stable
//             rd_en, rd_addr, rd_data  - synchronous RAM read port (1 cycle)
//             conv_done, sel_idx       - status of the displayed element
//             a..g, dp, anode          - active-low display drive
//  Revision : 1.0 - initial release
// ============================================================================
module result_readout #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 2,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_clean,
    input  logic              left_clean,
    input  logic              right_clean,
    input  logic              down_clean,
    input  logic              results_valid,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              conv_done,
    output logic [1:0]        sel_idx,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic              d,
    output logic              e,
    output logic              f,
    output logic              g,
    output logic              dp,
    output logic [3:0]        anode
);

    localparam int c_DIGITS = 3;
    localparam int c_BCD_W  = 4 * c_DIGITS;
    localparam int c_CNT_W  = $clog2(DATA_W + 1);
    localparam int c_REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_CONV    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic                 r_up_q;
    logic                 r_left_q;
    logic                 r_right_q;
    logic                 r_down_q;
    logic [3:0]           w_rise;
    logic                 w_accept;
    logic [1:0]           w_req_idx;

    logic [1:0]           r_idx;
    logic [DATA_W-1:0]    r_bin;
    logic [c_BCD_W-1:0]   r_bcd;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic                 w_last_iter;
    logic [c_BCD_W-1:0]   w_bcd_adj;
    logic [c_BCD_W-1:0]   w_bcd_shift;
    logic [DATA_W-1:0]    w_bin_shift;

    logic [c_BCD_W-1:0]   r_disp_bcd;
    logic [1:0]           r_sel_idx;
    logic                 r_shown;
    logic                 r_conv_done;

    logic [c_REF_W-1:0]   r_refresh;
    logic [1:0]           r_digit;
    logic [3:0]           w_glyph;
    logic                 w_blank;
    logic                 w_dp_on;
    logic [6:0]           w_seg_on;
    logic [6:0]           w_segs;

    // ------------------------------------------------------------------
    // Button edge detection with fixed priority up > left > right > down
    // ------------------------------------------------------------------
    assign w_rise = {down_clean  & ~r_down_q,
                     right_clean & ~r_right_q,
                     left_clean  & ~r_left_q,
                     up_clean    & ~r_up_q};

    always_comb begin
        w_req_idx = 2'd0;
        if (w_rise[0])      w_req_idx = 2'd0;
        else if (w_rise[1]) w_req_idx = 2'd1;
        else if (w_rise[2]) w_req_idx = 2'd2;
        else if (w_rise[3]) w_req_idx = 2'd3;
    end

    assign w_accept    = (r_state == S_IDLE) && results_valid && (|w_rise);
    assign w_last_iter = (r_bit_cnt == c_CNT_W'(DATA_W - 1));

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_next = S_READ;
            S_READ:    w_state_next = S_WAIT;
            S_WAIT:    w_state_next = S_CAPTURE;
            S_CAPTURE: w_state_next = S_CONV;
            S_CONV:    if (w_last_iter) w_state_next = S_DONE;
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
        // A new multiply run invalidates whatever is being read
        if (!results_valid) w_state_next = S_IDLE;
    end

    assign rd_en   = (r_state == S_READ) && results_valid;
    assign rd_addr = ADDR_W'(r_idx);

    // ------------------------------------------------------------------
    // One double-dabble step: add 3 to nibbles >= 5, then shift left
    // ------------------------------------------------------------------
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < c_DIGITS; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5)
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
        w_bcd_shift = {w_bcd_adj[c_BCD_W-2:0], r_bin[DATA_W-1]};
        w_bin_shift = {r_bin[DATA_W-2:0], 1'b0};
    end

    // ------------------------------------------------------------------
    // Datapath and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_up_q      <= 1'b0;
            r_left_q    <= 1'b0;
            r_right_q   <= 1'b0;
            r_down_q    <= 1'b0;
            r_idx       <= 2'd0;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_bit_cnt   <= '0;
            r_disp_bcd  <= '0;
            r_sel_idx   <= 2'd0;
            r_shown     <= 1'b0;
            r_conv_done <= 1'b0;
        end else begin
            // Edge registers track the buttons even while requests are ignored
            r_up_q    <= up_clean;
            r_left_q  <= left_clean;
            r_right_q <= right_clean;
            r_down_q  <= down_clean;

            if (!results_valid) begin
                r_shown     <= 1'b0;
                r_conv_done <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_idx       <= w_req_idx;
                    r_conv_done <= 1'b0;
                end
                if (r_state == S_CAPTURE) begin
                    r_bin     <= rd_data;
                    r_bcd     <= '0;
                    r_bit_cnt <= '0;
                end
                if (r_state == S_CONV) begin
                    r_bin     <= w_bin_shift;
                    r_bcd     <= w_bcd_shift;
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    // Result is published on entry to DONE so conv_done and
                    // the display registers change in the same cycle.
                    if (w_last_iter) begin
                        r_disp_bcd  <= w_bcd_shift;
                        r_sel_idx   <= r_idx;
                        r_shown     <= 1'b1;
                        r_conv_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign conv_done = r_conv_done;
    assign sel_idx   = r_sel_idx;

    // ------------------------------------------------------------------
    // Display refresh: digit scan 3 -> 2 -> 1 -> 0 -> 3
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh <= '0;
            r_digit   <= 2'd3;
        end else if (r_refresh == c_REF_W'(REFRESH_DIV - 1)) begin
            r_refresh <= '0;
            r_digit   <= r_digit - 2'd1;
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

    always_comb begin
        w_glyph = 4'd0;
        w_blank = 1'b0;
        w_dp_on = 1'b0;
        case (r_digit)
            2'd3: begin
                w_glyph = {2'b00, r_sel_idx} + 4'd1;
                w_dp_on = 1'b1;
            end
            2'd2: begin
                w_glyph = r_disp_bcd[11:8];
                w_blank = (r_disp_bcd[11:8] == 4'd0);
            end
            2'd1: begin
                w_glyph = r_disp_bcd[7:4];
                w_blank = (r_disp_bcd[11:8] == 4'd0) && (r_disp_bcd[7:4] == 4'd0);
            end
            default: w_glyph = r_disp_bcd[3:0];
        endcase

        // Active-high pattern ordered {a,b,c,d,e,f,g}
        case (w_glyph)
            4'd0:    w_seg_on = 7'b1111110;
            4'd1:    w_seg_on = 7'b0110000;
            4'd2:    w_seg_on = 7'b1101101;
            4'd3:    w_seg_on = 7'b1111001;
            4'd4:    w_seg_on = 7'b0110011;
            4'd5:    w_seg_on = 7'b1011011;
            4'd6:    w_seg_on = 7'b1011111;
            4'd7:    w_seg_on = 7'b1110000;
            4'd8:    w_seg_on = 7'b1111111;
            4'd9:    w_seg_on = 7'b1111011;
            default: w_seg_on = 7'b0000000;
        endcase

        if (r_shown) begin
            anode  = ~(4'b0001 << r_digit);
            w_segs = w_blank ? 7'h7F : ~w_seg_on;
            dp     = ~w_dp_on;
        end else begin
            anode  = 4'b1111;
            w_segs = 7'h7F;
            dp     = 1'b1;
        end
    end

    assign {a, b, c, d, e, f, g} = w_segs;

endmodule
`default_nettype wire

// File: tb/tb_result_readout.sv
`default_nettype none
// ============================================================================
//  Module   : tb_result_readout
//  Purpose  : Self-checking bench for result_readout: table vectors, hand
//             sequences for multi-cycle corners and randomized presses
//             checked against an arithmetic display model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_result_readout;

    localparam int DATA_W      = 8;
    localparam int ADDR_W      = 2;
    localparam int REFRESH_DIV = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        btn;   // {down, right, left, up}
    logic              results_valid;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              conv_done;
    logic [1:0]        sel_idx;
    logic              a, b, c, d, e, f, g, dp;
    logic [3:0]        anode;

    logic [7:0]        ram [4];
    int                rd_count = 0;
    logic [ADDR_W-1:0] last_addr = '0;

    int n_checks = 0;
    int n_fail   = 0;

    result_readout #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .up_clean      (btn[0]),
        .left_clean    (btn[1]),
        .right_clean   (btn[2]),
        .down_clean    (btn[3]),
        .results_valid (results_valid),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .conv_done     (conv_done),
        .sel_idx       (sel_idx),
        .a             (a),
        .b             (b),
        .c             (c),
        .d             (d),
        .e             (e),
        .f             (f),
        .g             (g),
        .dp            (dp),
        .anode         (anode)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model: output updates one cycle after rd_en and holds
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data   <= ram[rd_addr];
            rd_count  <= rd_count + 1;
            last_addr <= rd_addr;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Active-low {a..g} -> digit, 4'hF for dark digit, 4'hD for garbage
    function automatic logic [3:0] decode(input logic [6:0] s);
        logic [6:0] on;
        on = ~s;
        case (on)
            7'b1111110: return 4'd0;
            7'b0110000: return 4'd1;
            7'b1101101: return 4'd2;
            7'b1111001: return 4'd3;
            7'b0110011: return 4'd4;
            7'b1011011: return 4'd5;
            7'b1011111: return 4'd6;
            7'b1110000: return 4'd7;
            7'b1111111: return 4'd8;
            7'b1111011: return 4'd9;
            7'b0000000: return 4'hF;
            default:    return 4'hD;
        endcase
    endfunction

    // Expected display {digit3, hundreds, tens, ones}; 4'hF = blanked
    function automatic logic [15:0] model_disp(input int idx, input int val);
        int h, t, o;
        logic [3:0] hc, tc;
        h  = val / 100;
        t  = (val / 10) % 10;
        o  = val % 10;
        hc = (h == 0) ? 4'hF : 4'(h);
        tc = (h == 0 && t == 0) ? 4'hF : 4'(t);
        return {4'(idx + 1), hc, tc, 4'(o)};
    endfunction

    function automatic int prio_idx(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return -1;
    endfunction

    // Observe one full scan; unseen positions stay 4'hE
    task automatic scan(output logic [15:0] disp, output int bad);
        int p;
        disp = 16'hEEEE;
        bad  = 0;
        for (int k = 0; k < 4 * REFRESH_DIV + 1; k++) begin
            @(negedge clk);
            if (anode != 4'b1111) begin
                case (anode)
                    4'b1110: p = 0;
                    4'b1101: p = 1;
                    4'b1011: p = 2;
                    4'b0111: p = 3;
                    default: p = -1;
                endcase
                if (p < 0) bad++;
                else begin
                    disp[p*4 +: 4] = decode({a, b, c, d, e, f, g});
                    if ((dp == 1'b0) != (p == 3)) bad++;
                end
            end
        end
    endtask

    // Drive a press for a fixed 30-cycle window; report first conv_done cycle
    task automatic run_press(input logic [3:0] mask, input int hold,
                             input logic [3:0] extra, input int extra_at,
                             output int done_at, output int reads, output int lit);
        int r0;
        @(negedge clk);
        r0      = rd_count;
        btn     = mask;
        done_at = 0;
        lit     = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (conv_done && done_at == 0) done_at = k;
            if (anode != 4'b1111) lit++;
            if (k == hold) btn = 4'b0000;
            if (k == extra_at) btn = btn | extra;
        end
        btn   = 4'b0000;
        reads = rd_count - r0;
    endtask

    task automatic verify_press(input string name, input logic [3:0] mask, input int hold,
                                input logic [3:0] extra, input int extra_at,
                                input int exp_idx, input logic [15:0] exp_disp);
        int done_at, reads, lit, bad;
        logic [15:0] disp;
        run_press(mask, hold, extra, extra_at, done_at, reads, lit);
        check($sformatf("%s conv_done latency", name), done_at, 12);
        check($sformatf("%s read count", name), reads, 1);
        check($sformatf("%s read addr", name), last_addr, exp_idx);
        check($sformatf("%s sel_idx", name), sel_idx, exp_idx);
        check($sformatf("%s conv_done level", name), conv_done, 1);
        scan(disp, bad);
        check($sformatf("%s display", name), disp, exp_disp);
        check($sformatf("%s scan shape", name), bad, 0);
    endtask

    typedef struct {
        string      name;
        logic [3:0] mask;
        logic [7:0] ram0;
        int         exp_idx;
        logic [15:0] exp_disp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int done_at, reads, lit, r0, seen;
        logic [3:0] mask;
        int idx;

        rst           = 1'b1;
        btn           = 4'b0000;
        results_valid = 1'b0;
        ram[0] = 8'd3; ram[1] = 8'd13; ram[2] = 8'd1; ram[3] = 8'd7;

        vecs[0] = '{"up",        4'b0001, 8'd3,   0, 16'h1FF3};
        vecs[1] = '{"left",      4'b0010, 8'd3,   1, 16'h2F13};
        vecs[2] = '{"right",     4'b0100, 8'd3,   2, 16'h3FF1};
        vecs[3] = '{"down",      4'b1000, 8'd3,   3, 16'h4FF7};
        vecs[4] = '{"up_255",    4'b0001, 8'd255, 0, 16'h1255};
        vecs[5] = '{"up_0",      4'b0001, 8'd0,   0, 16'h1FF0};
        vecs[6] = '{"up+down",   4'b1001, 8'd3,   0, 16'h1FF3};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset rd_en", rd_en, 0);
        check("reset rd_addr", rd_addr, 0);
        check("reset conv_done", conv_done, 0);
        check("reset sel_idx", sel_idx, 0);
        check("reset anode", anode, 4'b1111);
        check("reset segments", {a, b, c, d, e, f, g, dp}, 8'hFF);
        rst = 1'b0;
        results_valid = 1'b1;
        @(negedge clk);

        // Table vectors
        for (int i = 0; i < 7; i++) begin
            ram[0] = vecs[i].ram0;
            verify_press(vecs[i].name, vecs[i].mask, 2, 4'b0000, 0,
                         vecs[i].exp_idx, vecs[i].exp_disp);
        end
        ram[0] = 8'd3;

        // Re-press during CONV is ignored, not queued
        verify_press("left+right_in_conv", 4'b0010, 2, 4'b0100, 6, 1, 16'h2F13);

        // Held button yields exactly one request
        verify_press("held_up", 4'b0001, 30, 4'b0000, 0, 0, 16'h1FF3);

        // Dropping results_valid blanks the display on the next cycle
        @(negedge clk);
        results_valid = 1'b0;
        @(negedge clk);
        check("valid_drop anode", anode, 4'b1111);
        check("valid_drop conv_done", conv_done, 0);
        run_press(4'b0001, 2, 4'b0000, 0, done_at, reads, lit);
        check("invalid press reads", reads, 0);
        check("invalid press lit", lit, 0);
        check("invalid press done", done_at, 0);
        results_valid = 1'b1;

        // Valid drop mid-conversion aborts
        @(negedge clk);
        btn = 4'b0001;
        repeat (6) @(negedge clk);
        results_valid = 1'b0;
        @(negedge clk);
        check("abort conv_done", conv_done, 0);
        check("abort rd_en", rd_en, 0);
        btn = 4'b0000;
        results_valid = 1'b1;
        r0 = rd_count;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (conv_done) seen = 1;
        end
        check("abort no completion", seen, 0);
        check("abort no read", rd_count - r0, 0);

        // Reset in the middle of a conversion
        @(negedge clk);
        btn = 4'b0010;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset anode", anode, 4'b1111);
        check("midreset conv_done", conv_done, 0);
        check("midreset rd_en", rd_en, 0);
        @(negedge clk);
        btn = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        verify_press("after_reset_left", 4'b0010, 2, 4'b0000, 0, 1, 16'h2F13);

        // Randomized presses against the arithmetic model
        for (int it = 0; it < 20; it++) begin
            for (int j = 0; j < 4; j++) ram[j] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) mask = 4'($urandom_range(1, 15));
            else                           mask = 4'b0001 << $urandom_range(0, 3);
            idx = prio_idx(mask);
            verify_press($sformatf("rand%0d", it), mask, 2, 4'b0000, 0,
                         idx, model_disp(idx, int'(ram[idx])));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
